// File: rtl/gcd_stim_driver.sv
// Stimulus driver for a GCD unit: sweeps every nonzero (a,b) operand pair, checks each
// result against an internal subtractive reference, and keeps pass/fail/timeout tallies.
module gcd_stim_driver #(
    parameter int W       = 2,
    parameter int TIMEOUT = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         io_start,
    output logic [W-1:0] io_value1,
    output logic [W-1:0] io_value2,
    output logic         io_loadingValues,
    input  logic [W-1:0] io_outputGCD,
    input  logic         io_outputValid,
    output logic         io_busy,
    output logic         io_done,
    output logic [7:0]   io_passCount,
    output logic [7:0]   io_failCount,
    output logic         io_timeout
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [W-1:0]  MAXV = '1;
    localparam logic [W-1:0]  ONE  = W'(1);
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_WAIT, S_CHECK, S_DONE
    } state_t;

    state_t        state;
    logic [W-1:0]  a, b;
    logic [W-1:0]  rx, ry;
    logic [W-1:0]  captured;
    logic [TW-1:0] tcnt;

    logic hit, tmo, advance, last_a, last_b;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // The unit's result is trusted only once the reference has also converged (ry==0).
    always_comb begin
        hit     = io_outputValid && (ry == '0);
        tmo     = (state == S_WAIT) && !hit && (tcnt == TLIM - 1'b1);
        advance = (state == S_CHECK) || tmo;
        last_a  = (a == MAXV);
        last_b  = (b == MAXV);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= S_IDLE;
            a                <= ONE;
            b                <= ONE;
            rx               <= '0;
            ry               <= '0;
            tcnt             <= '0;
            io_value1        <= '0;
            io_value2        <= '0;
            io_loadingValues <= 1'b0;
            io_busy          <= 1'b0;
            io_done          <= 1'b0;
            io_passCount     <= 8'd0;
            io_failCount     <= 8'd0;
            io_timeout       <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (io_start) begin
                        state            <= S_LOAD;
                        a                <= ONE;
                        b                <= ONE;
                        io_value1        <= ONE;
                        io_value2        <= ONE;
                        io_loadingValues <= 1'b1;
                        io_busy          <= 1'b1;
                        io_done          <= 1'b0;
                        io_passCount     <= 8'd0;
                        io_failCount     <= 8'd0;
                        io_timeout       <= 1'b0;
                    end
                end
                S_LOAD: begin
                    rx               <= a;
                    ry               <= b;
                    tcnt             <= '0;
                    io_loadingValues <= 1'b0;
                    state            <= S_SETTLE;
                end
                S_SETTLE: state <= S_WAIT;
                S_WAIT: begin
                    if (hit) begin
                        state <= S_CHECK;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                        if (tmo) begin
                            io_failCount <= sat_inc(io_failCount);
                            io_timeout   <= 1'b1;
                        end
                    end
                end
                S_CHECK: begin
                    if (captured == rx) io_passCount <= sat_inc(io_passCount);
                    else                io_failCount <= sat_inc(io_failCount);
                end
                default: state <= S_IDLE;
            endcase

            // Reference model steps in lockstep with the unit from the cycle after LOAD.
            if ((state == S_SETTLE || state == S_WAIT) && ry != '0) begin
                if (rx > ry) rx <= rx - ry;
                else         ry <= ry - rx;
            end

            if (advance) begin
                if (!last_b) begin
                    b                <= b + ONE;
                    io_value1        <= a;
                    io_value2        <= b + ONE;
                    io_loadingValues <= 1'b1;
                    state            <= S_LOAD;
                end else if (!last_a) begin
                    a                <= a + ONE;
                    b                <= ONE;
                    io_value1        <= a + ONE;
                    io_value2        <= ONE;
                    io_loadingValues <= 1'b1;
                    state            <= S_LOAD;
                end else begin
                    io_busy <= 1'b0;
                    io_done <= 1'b1;
                    state   <= S_DONE;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (state == S_WAIT && hit) captured <= io_outputGCD;
    end

endmodule

// File: tb/tb_gcd_stim_driver.sv
// Bench for gcd_stim_driver: a behavioural GCD unit with fault modes, and a scoreboard
// of expected load pairs plus end-of-sweep tallies.
module tb_gcd_stim_driver;

    localparam int W       = 2;
    localparam int TIMEOUT = 16;

    logic         clock = 1'b0;
    logic         reset;
    logic         io_start;
    logic [W-1:0] io_value1, io_value2;
    logic         io_loadingValues;
    logic [W-1:0] io_outputGCD;
    logic         io_outputValid;
    logic         io_busy, io_done, io_timeout;
    logic [7:0]   io_passCount, io_failCount;

    gcd_stim_driver #(.W(W), .TIMEOUT(TIMEOUT)) dut (
        .clock            (clock),
        .reset            (reset),
        .io_start         (io_start),
        .io_value1        (io_value1),
        .io_value2        (io_value2),
        .io_loadingValues (io_loadingValues),
        .io_outputGCD     (io_outputGCD),
        .io_outputValid   (io_outputValid),
        .io_busy          (io_busy),
        .io_done          (io_done),
        .io_passCount     (io_passCount),
        .io_failCount     (io_failCount),
        .io_timeout       (io_timeout)
    );

    always #5 clock = ~clock;

    // Unit modes: 0 correct, 1 result forced to 2, 2 valid stuck low, 3 valid stuck high.
    int           mode = 0;
    logic [W-1:0] ux = '0, uy = '0;

    always @(posedge clock) begin
        if (io_loadingValues) begin
            ux <= io_value1;
            uy <= io_value2;
        end else if (uy != '0) begin
            if (ux > uy) ux <= ux - uy;
            else         uy <= uy - ux;
        end
    end

    assign io_outputValid = (mode == 2) ? 1'b0 : (mode == 3) ? 1'b1 : (uy == '0);
    assign io_outputGCD   = (mode == 1) ? W'(2) : ux;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int gcd(input int x, input int y);
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    typedef struct { int a; int b; } pair_t;
    pair_t sb[$];

    int cyc = 0;
    int last_cyc = 0;
    bit first_load = 1'b1;

    always @(posedge clock) cyc <= cyc + 1;

    // Every load strobe must match the next expected pair, in order.
    always @(negedge clock) begin
        if (!reset && io_loadingValues) begin
            pair_t p;
            check("load_expected", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                p = sb.pop_front();
                check("load_a", 32'(io_value1), p.a);
                check("load_b", 32'(io_value2), p.b);
            end
            if (mode == 2 && !first_load) check("wait_cycles", cyc - last_cyc, TIMEOUT + 2);
            first_load = 1'b0;
            last_cyc   = cyc;
        end
    end

    task automatic run_sweep(input int m, input bit poke);
        int exp_pass = 0;
        int exp_fail = 0;
        mode       = m;
        first_load = 1'b1;
        for (int a = 1; a < (1 << W); a++) begin
            for (int b = 1; b < (1 << W); b++) begin
                int  g, o;
                bit  ok;
                pair_t p;
                g   = gcd(a, b);
                o   = (m == 1) ? 2 : g;
                ok  = (m != 2) && (o == g);
                p.a = a;
                p.b = b;
                sb.push_back(p);
                if (ok) exp_pass++;
                else    exp_fail++;
            end
        end
        io_start = 1'b1;
        @(negedge clock);
        io_start = 1'b0;
        check("start_strobe", 32'(io_loadingValues), 1);
        check("start_pass_clr", 32'(io_passCount), 0);
        check("start_fail_clr", 32'(io_failCount), 0);
        check("start_tmo_clr", 32'(io_timeout), 0);
        check("start_busy", 32'(io_busy), 1);
        check("start_done", 32'(io_done), 0);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clock);
            io_start = (poke && i == 20);
            if (io_done) break;
        end
        io_start = 1'b0;
        check("end_done", 32'(io_done), 1);
        check("end_busy", 32'(io_busy), 0);
        check("end_pass", 32'(io_passCount), exp_pass);
        check("end_fail", 32'(io_failCount), exp_fail);
        check("end_timeout", 32'(io_timeout), (m == 2) ? 1 : 0);
        check("sb_drained", 32'(sb.size()), 0);
        repeat (3) @(negedge clock);
        check("done_hold_pass", 32'(io_passCount), exp_pass);
        check("done_hold_done", 32'(io_done), 1);
    endtask

    initial begin
        bit found;
        reset    = 1'b1;
        io_start = 1'b1;
        repeat (2) @(negedge clock);
        check("rst_v1", 32'(io_value1), 0);
        check("rst_v2", 32'(io_value2), 0);
        check("rst_load", 32'(io_loadingValues), 0);
        check("rst_busy", 32'(io_busy), 0);
        check("rst_done", 32'(io_done), 0);
        check("rst_pass", 32'(io_passCount), 0);
        check("rst_fail", 32'(io_failCount), 0);
        check("rst_tmo", 32'(io_timeout), 0);
        io_start = 1'b0;
        reset    = 1'b0;
        repeat (5) @(negedge clock);
        check("idle_no_load", 32'(io_loadingValues), 0);
        check("idle_busy", 32'(io_busy), 0);

        run_sweep(0, 1'b1);
        run_sweep(1, 1'b0);
        run_sweep(2, 1'b0);
        run_sweep(3, 1'b0);

        // Reset in the middle of the WAIT phase of pair (2,3).
        mode  = 0;
        found = 1'b0;
        for (int a = 1; a < (1 << W); a++) begin
            for (int b = 1; b < (1 << W); b++) begin
                pair_t p;
                p.a = a;
                p.b = b;
                sb.push_back(p);
            end
        end
        io_start = 1'b1;
        @(negedge clock);
        io_start = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (io_loadingValues && io_value1 == W'(2) && io_value2 == W'(3)) begin
                found = 1'b1;
                break;
            end
            @(negedge clock);
        end
        check("found_pair_23", 32'(found), 1);
        repeat (2) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_v1", 32'(io_value1), 0);
        check("mid_rst_v2", 32'(io_value2), 0);
        check("mid_rst_busy", 32'(io_busy), 0);
        check("mid_rst_done", 32'(io_done), 0);
        check("mid_rst_pass", 32'(io_passCount), 0);
        check("mid_rst_load", 32'(io_loadingValues), 0);
        sb.delete();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (6) @(negedge clock);
        check("post_rst_idle_busy", 32'(io_busy), 0);
        check("post_rst_idle_done", 32'(io_done), 0);
        run_sweep(0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
